uart_rx: RTL and testbench

- Receive half of the UART link. Deserializes the 11-bit frame produced by the transmit block into a parallel byte.
- Frame: start(0), DATA_WIDTH data bits LSB first, parity bit, stop(1).
- Parity bit = XOR of data bits (even parity over data+parity). Bit period = prescale*8 clk cycles.
- Sits between the rxd pad and the AXI-Lite register block. Presents bytes with a valid/ready handshake and flags errors.

---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start / DATA_WIDTH data bits (LSB first) / even parity / stop.
// Bit period is prescale*8 clocks. Received bytes are presented on a
// valid/ready handshake. Parity, framing and overrun conditions are reported
// as single-cycle pulses.
// Optional build macro UART_RX_MAJORITY_EN: every sample point takes the 2-of-3
// majority of the synchronized line at timer=2,1,0 instead of a single sample.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun_error
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                state_q;
    logic                  rxd_meta_q;
    logic                  rxs_q;
    logic [18:0]           timer_q;
    logic [15:0]           p_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  parity_error_q;
    logic                  framing_error_q;
    logic                  overrun_error_q;

    logic                  sample_bit;
    logic [18:0]           half_load;
    logic [18:0]           full_load;

    // Half period uses the live prescale because it is loaded in the same
    // cycle that prescale is latched; full period uses the latched copy.
    assign half_load = {1'b0, prescale, 2'b00} - 19'd1;
    assign full_load = {p_q, 3'b000} - 19'd1;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxs_q      <= rxd_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // History of the two previous synchronized samples (timer=2 and timer=1
    // when the timer reaches 0), used to vote out a single-cycle glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs_q};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
    assign sample_bit = rxs_q;
`endif

    // Frame FSM: bit timing, deserialization, frame checks and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            p_q             <= '0;
            cnt_q           <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q && (prescale != 16'd0)) begin
                        p_q     <= prescale;
                        timer_q <= half_load;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 19'd1;
                    end else if (sample_bit) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= full_load;
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 19'd1;
                    end else begin
                        shift_q[cnt_q] <= sample_bit;
                        timer_q        <= full_load;
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            state_q <= S_PARITY;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 19'd1;
                    end else begin
                        par_q   <= sample_bit;
                        timer_q <= full_load;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 19'd1;
                    end else if (!sample_bit) begin
                        framing_error_q <= 1'b1;
                        state_q         <= S_WAIT_IDLE;
                    end else if (par_q != (^shift_q)) begin
                        parity_error_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else if (rx_valid_q && !rx_ready) begin
                        overrun_error_q <= 1'b1;
                        state_q         <= S_IDLE;
                    end else begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: reset, nominal reception and latency,
// parity / framing / overrun errors, back-to-back frames, false starts,
// optional majority voting and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic [15:0] prescale;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        parity_error;
    logic        framing_error;
    logic        overrun_error;

    int checks;
    int errors;
    int n_par;
    int n_frm;
    int n_ovr;
    int lat_meas;
    logic [7:0] exp_q[$];

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .prescale      (prescale),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .busy          (busy),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles each error flag is high; a one-cycle pulse adds exactly 1.
    always @(negedge clk) begin
        if (parity_error)  n_par++;
        if (framing_error) n_frm++;
        if (overrun_error) n_ovr++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Drive one frame starting at a falling clock edge. gbit selects a data bit
    // that receives a one-clock inverted glitch at its sample point (-1: none).
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v,
                              input int p, input int gbit);
        rxd = 1'b0;
        repeat (8 * p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == gbit) begin
                repeat (4 * p) @(negedge clk);
                rxd = ~d[i];
                @(negedge clk);
                rxd = d[i];
                repeat (4 * p - 1) @(negedge clk);
            end else begin
                repeat (8 * p) @(negedge clk);
            end
        end
        rxd = (^d) ^ bad_par;
        repeat (8 * p) @(negedge clk);
        rxd = stop_v;
        repeat (8 * p) @(negedge clk);
        if (stop_v) rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if ({parity_error, framing_error, overrun_error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {parity_error, framing_error, overrun_error});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int p0, f0, o0, lat;
        logic [7:0] e;
        prescale = 16'd2;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 2, -1);
            begin
                while (rx_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
            end
        join
        lat_meas = lat;
        // 2 sync + 4P + 80P + 1 = 171 clocks from the rxd fall, +/-2 allowed.
        checks++;
        if (lat < 169 || lat > 173) begin errors++; $display("FAIL basic_latency: got %0d cycles want 169..173", lat); end
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b want 1", rx_valid);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin errors++; $display("FAIL basic_data: got %h want %h", rx_data, e); end
        end
        checks++;
        if ((n_par - p0) + (n_frm - f0) + (n_ovr - o0) != 0) begin
            errors++; $display("FAIL basic_flags: got %0d flag cycles want 0", (n_par - p0) + (n_frm - f0) + (n_ovr - o0));
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b want 0", rx_valid); end
    endtask

    task automatic test_parity();
        int p0, f0, o0;
        prescale = 16'd2;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b1, 2, -1);
        repeat (2) @(negedge clk);
        checks++; if (n_par - p0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d cycles want 1", n_par - p0); end
        checks++;
        if ((n_frm - f0) + (n_ovr - o0) != 0) begin errors++; $display("FAIL parity_other_flags: got %0d want 0", (n_frm - f0) + (n_ovr - o0)); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_valid: got %b want 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_busy: got %b want 0", busy); end
    endtask

    task automatic test_framing();
        int p0, f0, o0, n;
        logic [7:0] e;
        prescale = 16'd2;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        send_frame(8'h3C, 1'b0, 1'b0, 2, -1);
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL framing_busy_low: got %b want 1", busy); end
        checks++; if (n_frm - f0 != 1) begin errors++; $display("FAIL framing_pulse: got %0d cycles want 1", n_frm - f0); end
        checks++;
        if ((n_par - p0) + (n_ovr - o0) != 0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL framing_other: got flags=%0d valid=%b want 0/0", (n_par - p0) + (n_ovr - o0), rx_valid);
        end
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_release: got %b want 0", busy); end
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b0, 1'b1, 2, -1);
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++; $display("FAIL framing_next_valid: got %b want 1", rx_valid);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin errors++; $display("FAIL framing_next_data: got %h want %h", rx_data, e); end
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int p0, f0, o0, n;
        logic [7:0] e;
        prescale = 16'd2;
        rx_ready = 1'b0;
        // Overrun: second byte arrives while the first is still held.
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 2, -1);
        send_frame(8'h22, 1'b0, 1'b1, 2, -1);
        @(negedge clk);
        checks++; if (n_ovr - o0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles want 1", n_ovr - o0); end
        checks++;
        if ((n_par - p0) + (n_frm - f0) != 0) begin errors++; $display("FAIL overrun_other_flags: got %0d want 0", (n_par - p0) + (n_frm - f0)); end
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++; $display("FAIL overrun_valid: got %b want 1", rx_valid);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin errors++; $display("FAIL overrun_kept: got %h want %h", rx_data, e); end
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        // Accept in the same cycle the next byte completes: no overrun.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 2, -1);
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        e = exp_q.pop_front();
        if (rx_valid !== 1'b1 || rx_data !== e) begin
            errors++; $display("FAIL b2b_first: got valid=%b data=%h want 1/%h", rx_valid, rx_data, e);
        end
        o0 = n_ovr;
        exp_q.push_back(8'h22);
        @(negedge clk);
        fork
            send_frame(8'h22, 1'b0, 1'b1, 2, -1);
            begin
                repeat (lat_meas - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                checks++;
                e = exp_q.pop_front();
                if (rx_valid !== 1'b1 || rx_data !== e) begin
                    errors++; $display("FAIL b2b_same_cycle: got valid=%b data=%h want 1/%h", rx_valid, rx_data, e);
                end
            end
        join
        checks++; if (n_ovr - o0 != 0) begin errors++; $display("FAIL b2b_no_overrun: got %0d cycles want 0", n_ovr - o0); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_glitch();
        int p0, f0, o0;
        prescale = 16'd4;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        checks++;
        if ((n_par - p0) + (n_frm - f0) + (n_ovr - o0) != 0) begin
            errors++; $display("FAIL glitch_flags: got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_ovr - o0));
        end
`ifdef UART_RX_MAJORITY_EN
        begin
            int n;
            logic [7:0] e;
            exp_q.push_back(8'h5A);
            send_frame(8'h5A, 1'b0, 1'b1, 4, 3);
            n = 0;
            while (rx_valid !== 1'b1 && n < 800) begin @(negedge clk); n++; end
            checks++;
            e = exp_q.pop_front();
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                errors++; $display("FAIL majority_data: got valid=%b data=%h want 1/%h", rx_valid, rx_data, e);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
`endif
    endtask

    task automatic test_reset_mid();
        int p0, f0, o0, n;
        logic [7:0] e;
        prescale = 16'd2;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        @(negedge clk);
        fork
            send_frame(8'hFF, 1'b0, 1'b1, 2, -1);
            begin
                repeat (60) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", busy); end
                rst_n = 1'b0;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
                checks++;
                if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
                    errors++; $display("FAIL rstmid_outputs: got data=%h valid=%b want 00/0", rx_data, rx_valid);
                end
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ((n_par - p0) + (n_frm - f0) + (n_ovr - o0) != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: got flags=%0d busy=%b want 0/0", (n_par - p0) + (n_frm - f0) + (n_ovr - o0), busy);
        end
        exp_q.push_back(8'h80);
        send_frame(8'h80, 1'b0, 1'b1, 2, -1);
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        e = exp_q.pop_front();
        if (rx_valid !== 1'b1 || rx_data !== e) begin
            errors++; $display("FAIL rstmid_next: got valid=%b data=%h want 1/%h", rx_valid, rx_data, e);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        n_par    = 0;
        n_frm    = 0;
        n_ovr    = 0;
        lat_meas = 171;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        prescale = 16'd2;
        rst_n    = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_basic();
        repeat (10) @(negedge clk);
        test_parity();
        repeat (10) @(negedge clk);
        test_framing();
        repeat (10) @(negedge clk);
        test_back_to_back();
        repeat (10) @(negedge clk);
        test_glitch();
        repeat (10) @(negedge clk);
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
